pc_control: RTL and testbench

- Program-counter stage directly downstream of the 3-bit PC source mux (MUX6out) in the multicycle MIPS datapath.
- Holds the PC and EPC registers and decides when the PC loads: unconditional write, or a conditional branch resolved from ALU flags.
- Contains an exception sequencer. On an exception it saves EPC, fetches the handler address byte from memory, and forces the PC mux select to the memory input.
- Only the exception sequencer overrides the main control unit's PC mux select.

---
 rtl/pc_control.sv | 106 ++++++++++
 tb/tb_pc_control.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pc_control.sv
// Program-counter stage: PC/EPC registers, branch resolution and exception sequencer.
// Latency: PC loads on the edge after a write request; an exception reaches its handler PC in 4 edges.
// Backpressure: excp_busy is high while the sequencer runs; the control unit must stall, and PC writes and new exceptions are ignored.
module pc_control #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] VEC_OPCODE = 32'd253,
  parameter logic [31:0] VEC_OVF    = 32'd254,
  parameter logic [31:0] VEC_DIV0   = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MUX6out,
  input  logic [2:0]  PCmux_ctrl,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic [1:0]  BranchOp,
  input  logic        Zero,
  input  logic        Gt,
  input  logic [2:0]  excp_req,
  output logic [2:0]  PCmux,
  output logic [31:0] PC,
  output logic [31:0] EPC,
  output logic [31:0] excp_addr,
  output logic        excp_mem_rd,
  output logic [1:0]  excp_cause,
  output logic        excp_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WAIT = 2'd2,
    S_LOAD = 2'd3
  } state_t;

  // Select value that steers the upstream mux to its memory input.
  localparam logic [2:0] MUX_MEM = 3'b110;

  state_t state;
  logic   take;

  // Branch condition from ALU flags.
  always_comb begin
    take = 1'b0;
    case (BranchOp)
      2'b00:   take = Zero;
      2'b01:   take = !Zero;
      2'b10:   take = Zero | !Gt;
      default: take = Gt & !Zero;
    endcase
  end

  // Only the LOAD step of the sequencer overrides the control unit's select.
  assign PCmux = (state == S_LOAD) ? MUX_MEM : PCmux_ctrl;

  // PC update and exception sequencer; mem_rd and busy are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      PC          <= RESET_PC;
      EPC         <= 32'd0;
      excp_addr   <= 32'd0;
      excp_mem_rd <= 1'b0;
      excp_cause  <= 2'd0;
      excp_busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (excp_req != 3'b000) begin
            // Exception wins over any PC write requested in the same cycle.
            EPC         <= PC - 32'd4;
            excp_mem_rd <= 1'b1;
            excp_busy   <= 1'b1;
            state       <= S_RD;
            if (excp_req[2]) begin
              excp_cause <= 2'd1;
              excp_addr  <= VEC_OPCODE;
            end else if (excp_req[1]) begin
              excp_cause <= 2'd2;
              excp_addr  <= VEC_OVF;
            end else begin
              excp_cause <= 2'd3;
              excp_addr  <= VEC_DIV0;
            end
          end else if (PCWrite || (PCWriteCond && take)) begin
            PC <= MUX6out;
          end
        end
        S_RD: begin
          excp_mem_rd <= 1'b0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          // Memory read latency; vector byte appears on MUX6out next cycle.
          state <= S_LOAD;
        end
        default: begin
          PC        <= MUX6out;
          excp_busy <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_control.sv
module tb_pc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MUX6out;
  logic [2:0]  PCmux_ctrl;
  logic        PCWrite;
  logic        PCWriteCond;
  logic [1:0]  BranchOp;
  logic        Zero;
  logic        Gt;
  logic [2:0]  excp_req;
  logic [2:0]  PCmux;
  logic [31:0] PC;
  logic [31:0] EPC;
  logic [31:0] excp_addr;
  logic        excp_mem_rd;
  logic [1:0]  excp_cause;
  logic        excp_busy;

  int total = 0;
  int bad   = 0;

  pc_control dut (
    .clk(clk), .reset(reset), .MUX6out(MUX6out), .PCmux_ctrl(PCmux_ctrl),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchOp(BranchOp),
    .Zero(Zero), .Gt(Gt), .excp_req(excp_req), .PCmux(PCmux), .PC(PC),
    .EPC(EPC), .excp_addr(excp_addr), .excp_mem_rd(excp_mem_rd),
    .excp_cause(excp_cause), .excp_busy(excp_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       wc;
    logic [1:0] bop;
    logic       z;
    logic       g;
    logic       exp_load;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PCWrite = 0; PCWriteCond = 0; BranchOp = 0; Zero = 0; Gt = 0; excp_req = 0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    idle_inputs();
    PCWrite = 1; MUX6out = v;
    tick();
    PCWrite = 0;
  endtask

  int busy_cnt;
  logic [31:0] base;

  initial begin
    //             wr wc  bop    z  g  load
    vecs[0]  = '{0, 1, 2'b00, 0, 0, 0};  // beq not taken
    vecs[1]  = '{0, 1, 2'b00, 1, 0, 1};  // beq taken
    vecs[2]  = '{0, 1, 2'b01, 0, 0, 1};  // bne taken
    vecs[3]  = '{0, 1, 2'b01, 1, 0, 0};  // bne not taken
    vecs[4]  = '{0, 1, 2'b10, 0, 0, 1};  // ble: !Gt
    vecs[5]  = '{0, 1, 2'b10, 0, 1, 0};  // ble: greater
    vecs[6]  = '{0, 1, 2'b10, 1, 1, 1};  // ble: equal
    vecs[7]  = '{0, 1, 2'b11, 0, 1, 1};  // bgt taken
    vecs[8]  = '{0, 1, 2'b11, 1, 1, 0};  // bgt with zero
    vecs[9]  = '{0, 1, 2'b11, 0, 0, 0};  // bgt not greater
    vecs[10] = '{1, 1, 2'b00, 0, 0, 1};  // PCWrite overrides failing branch
    vecs[11] = '{0, 0, 2'b00, 1, 1, 0};  // no request

    reset = 0; MUX6out = 0; PCmux_ctrl = 3'b001;
    idle_inputs();
    #2;
    chk("rst_pc", PC, 32'h0);
    chk("rst_epc", EPC, 32'h0);
    chk("rst_cause", {30'd0, excp_cause}, 32'd0);
    chk("rst_addr", excp_addr, 32'h0);
    chk("rst_memrd", {31'd0, excp_mem_rd}, 32'd0);
    chk("rst_busy", {31'd0, excp_busy}, 32'd0);

    // Release reset away from the edge, then plain PCWrite.
    #6; reset = 1;
    PCWrite = 1; MUX6out = 32'h4; PCmux_ctrl = 3'b001;
    #1;
    chk("pcmux_pass", {29'd0, PCmux}, 32'd1);
    tick();
    chk("pcwrite_pc", PC, 32'h4);
    chk("pcmux_pass2", {29'd0, PCmux}, 32'd1);

    // Branch table.
    for (int i = 0; i < 12; i++) begin
      base = 32'h1000 + 32'(i * 16);
      set_pc(base);
      PCWrite = vecs[i].wr; PCWriteCond = vecs[i].wc; BranchOp = vecs[i].bop;
      Zero = vecs[i].z; Gt = vecs[i].g; MUX6out = 32'h40 + 32'(i);
      PCmux_ctrl = 3'(i);
      #1;
      chk($sformatf("vec%0d_pcmux", i), {29'd0, PCmux}, 32'(i % 8));
      tick();
      chk($sformatf("vec%0d_pc", i), PC, vecs[i].exp_load ? 32'h40 + 32'(i) : base);
    end

    // Invalid-opcode exception (with overflow also set) from PC=0x100.
    PCmux_ctrl = 3'b001;
    set_pc(32'h100);
    busy_cnt = 0;
    excp_req = 3'b110; PCWrite = 1; MUX6out = 32'h999;
    tick();
    if (excp_busy) busy_cnt++;
    chk("ex_rd_memrd", {31'd0, excp_mem_rd}, 32'd1);
    chk("ex_rd_addr", excp_addr, 32'd253);
    chk("ex_cause", {30'd0, excp_cause}, 32'd1);
    chk("ex_epc", EPC, 32'hFC);
    chk("ex_pc_suppressed", PC, 32'h100);
    idle_inputs();
    tick();
    if (excp_busy) busy_cnt++;
    chk("ex_wait_memrd", {31'd0, excp_mem_rd}, 32'd0);
    chk("ex_wait_addr", excp_addr, 32'd253);
    // Requests during WAIT must be ignored.
    excp_req = 3'b001; PCWrite = 1; MUX6out = 32'h555;
    tick();
    if (excp_busy) busy_cnt++;
    chk("ex_load_pcmux", {29'd0, PCmux}, 32'd6);
    chk("ex_load_pc", PC, 32'h100);
    chk("ex_load_epc", EPC, 32'hFC);
    chk("ex_load_cause", {30'd0, excp_cause}, 32'd1);
    idle_inputs();
    MUX6out = 32'h0000_00A0;
    tick();
    if (excp_busy) busy_cnt++;
    chk("ex_handler_pc", PC, 32'hA0);
    chk("ex_idle_pcmux", {29'd0, PCmux}, 32'd1);
    chk("ex_busy_cycles", 32'(busy_cnt), 32'd3);
    chk("ex_epc_hold", EPC, 32'hFC);

    // Overflow exception from PC=0: EPC wraps.
    set_pc(32'h0);
    excp_req = 3'b010;
    tick();
    chk("ovf_epc", EPC, 32'hFFFF_FFFC);
    chk("ovf_addr", excp_addr, 32'd254);
    chk("ovf_cause", {30'd0, excp_cause}, 32'd2);
    idle_inputs();
    MUX6out = 32'hFE;
    tick(); tick(); tick();
    chk("ovf_handler_pc", PC, 32'hFE);
    chk("ovf_busy_done", {31'd0, excp_busy}, 32'd0);

    // Div-by-zero exception aborted by reset in WAIT.
    set_pc(32'h200);
    excp_req = 3'b001;
    tick();
    chk("div0_addr", excp_addr, 32'd255);
    chk("div0_cause", {30'd0, excp_cause}, 32'd3);
    idle_inputs();
    tick();
    chk("div0_wait_busy", {31'd0, excp_busy}, 32'd1);
    reset = 0;
    #1;
    chk("abort_pc", PC, 32'h0);
    chk("abort_busy", {31'd0, excp_busy}, 32'd0);
    chk("abort_memrd", {31'd0, excp_mem_rd}, 32'd0);
    chk("abort_cause", {30'd0, excp_cause}, 32'd0);
    chk("abort_epc", EPC, 32'h0);
    #2; reset = 1;
    PCWrite = 1; MUX6out = 32'h44;
    tick();
    chk("post_reset_pc", PC, 32'h44);
    chk("post_reset_pcmux", {29'd0, PCmux}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
